// File: rtl/preview_fifo_pkg.sv
// Command encodings and helpers shared by the preview FIFO.
package preview_fifo_pkg;

    localparam logic [2:0] CMD_IDLE = 3'b001;
    localparam logic [2:0] CMD_ONE  = 3'b010;
    localparam logic [2:0] CMD_TWO  = 3'b100;

    // Words a command asks to move; unknown codes and disabled two-word codes are idle.
    function automatic logic [1:0] cmd_words(input logic [2:0] cmd, input logic two_en);
        logic [1:0] n;
        n = 2'd0;
        if (cmd == CMD_ONE) begin
            n = 2'd1;
        end else if (cmd == CMD_TWO && two_en) begin
            n = 2'd2;
        end
        return n;
    endfunction

endpackage

// File: rtl/preview_fifo.sv
// First-word-fall-through FIFO with a two-word head preview and one/two-word transfers.
// Two-word commands are enabled by defining PREVIEW_FIFO_TWO_WORD_EN; otherwise they act as idle.
module preview_fifo
    import preview_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 wrreq,
    input  logic [WIDTH-1:0]           id0,
    input  logic [WIDTH-1:0]           id1,
    input  logic [2:0]                 rdreq,
    output logic [WIDTH-1:0]           od0,
    output logic [WIDTH-1:0]           od1,
    output logic [1:0]                 empty,
    output logic [1:0]                 full,
    output logic [$clog2(DEPTH)-1:0]   usedw
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] ONE       = AW'(1);
    localparam logic [AW-1:0] TWO       = AW'(2);
    localparam logic [AW-1:0] CAP       = AW'(DEPTH - 1);
    localparam logic [AW-1:0] CAP_MINUS = AW'(DEPTH - 2);

`ifdef PREVIEW_FIFO_TWO_WORD_EN
    localparam logic TWO_EN = 1'b1;
`else
    localparam logic TWO_EN = 1'b0;
`endif

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    usedw_q, usedw_d;
    logic [1:0]       empty_q, empty_d;
    logic [1:0]       full_q, full_d;

    logic [1:0]       wr_req_n, rd_req_n;
    logic             wr_one, wr_two, rd_one, rd_two;
    logic [AW-1:0]    wr_cnt, rd_cnt;
    logic [AW-1:0]    wr_ptr_p1, rd_ptr_p1;

    // Acceptance uses the registered flags, so a same-cycle read never makes room for a write.
    always_comb begin
        wr_req_n  = cmd_words(wrreq, TWO_EN);
        rd_req_n  = cmd_words(rdreq, TWO_EN);
        wr_one    = (wr_req_n == 2'd1) && !full_q[0];
        wr_two    = (wr_req_n == 2'd2) && !full_q[1];
        rd_one    = (rd_req_n == 2'd1) && !empty_q[0];
        rd_two    = (rd_req_n == 2'd2) && !empty_q[1];
        wr_cnt    = wr_two ? TWO : (wr_one ? ONE : '0);
        rd_cnt    = rd_two ? TWO : (rd_one ? ONE : '0);
        wr_ptr_p1 = wr_ptr_q + ONE;
        rd_ptr_p1 = rd_ptr_q + ONE;
        wr_ptr_d  = wr_ptr_q + wr_cnt;
        rd_ptr_d  = rd_ptr_q + rd_cnt;
        usedw_d   = usedw_q + wr_cnt - rd_cnt;
        empty_d   = {usedw_d < TWO, usedw_d == '0};
        full_d    = {usedw_d >= CAP_MINUS, usedw_d == CAP};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
            empty_q  <= 2'b11;
            full_q   <= 2'b00;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            if (wr_one || wr_two) begin
                mem_q[wr_ptr_q] <= id0;
            end
            // Pointer arithmetic wraps, so the second word lands in slot 0 after slot DEPTH-1.
            if (wr_two) begin
                mem_q[wr_ptr_p1] <= id1;
            end
        end
    end

    assign od0   = mem_q[rd_ptr_q];
    assign od1   = mem_q[rd_ptr_p1];
    assign empty = empty_q;
    assign full  = full_q;
    assign usedw = usedw_q;

endmodule

// File: tb/tb_preview_fifo.sv
// Directed bench for preview_fifo: a queue-based reference model feeds a scoreboard checked at negedge.
module tb_preview_fifo;

    localparam int W = 8;
    localparam int D = 32;

`ifdef PREVIEW_FIFO_TWO_WORD_EN
    localparam bit TWO_EN = 1'b1;
`else
    localparam bit TWO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   wrreq, rdreq;
    logic [W-1:0] id0, id1;
    logic [W-1:0] od0, od1;
    logic [1:0]   empty, full;
    logic [4:0]   usedw;

    preview_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .wrreq (wrreq),
        .id0   (id0),
        .id1   (id1),
        .rdreq (rdreq),
        .od0   (od0),
        .od1   (od1),
        .empty (empty),
        .full  (full),
        .usedw (usedw)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] usedw;
        logic [1:0] empty;
        logic [1:0] full;
        logic [7:0] od0;
        logic [7:0] od1;
        bit         chk0;
        bit         chk1;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    exp_t       mon_e;

    localparam logic [2:0] IDLE = 3'b001;
    localparam logic [2:0] ONE  = 3'b010;
    localparam logic [2:0] TWO  = 3'b100;

    // Drive one cycle of stimulus, then advance the model and queue what the DUT must show.
    task automatic step(input string name, input bit r, input logic [2:0] w,
                        input logic [7:0] d0, input logic [7:0] d1, input logic [2:0] rd);
        exp_t e;
        int n, rn, wn;
        rst = r; wrreq = w; id0 = d0; id1 = d1; rdreq = rd;
        @(posedge clk);
        #1;
        e.name = name;
        e.od0 = 8'h00; e.od1 = 8'h00; e.chk0 = 1'b0; e.chk1 = 1'b0;
        if (r) begin
            model_q.delete();
            e.chk0 = 1'b1; e.chk1 = 1'b1;
        end else begin
            n  = model_q.size();
            rn = (rd == ONE && n >= 1) ? 1 : ((TWO_EN && rd == TWO && n >= 2) ? 2 : 0);
            wn = (w == ONE && n <= D - 2) ? 1 : ((TWO_EN && w == TWO && n <= D - 3) ? 2 : 0);
            for (int i = 0; i < rn; i++) void'(model_q.pop_front());
            if (wn >= 1) model_q.push_back(d0);
            if (wn == 2) model_q.push_back(d1);
        end
        n = model_q.size();
        e.usedw = 5'(n);
        e.empty = {n < 2, n == 0};
        e.full  = {n >= D - 2, n == D - 1};
        if (n >= 1) begin e.od0 = model_q[0]; e.chk0 = 1'b1; end
        if (n >= 2) begin e.od1 = model_q[1]; e.chk1 = 1'b1; end
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            vectors++;
            if (usedw !== mon_e.usedw || empty !== mon_e.empty || full !== mon_e.full ||
                (mon_e.chk0 && od0 !== mon_e.od0) || (mon_e.chk1 && od1 !== mon_e.od1)) begin
                miscompares++;
                $display("FAIL %s: got usedw=%0d empty=%b full=%b od0=%h od1=%h; want usedw=%0d empty=%b full=%b od0=%h(chk%0d) od1=%h(chk%0d)",
                         mon_e.name, usedw, empty, full, od0, od1,
                         mon_e.usedw, mon_e.empty, mon_e.full, mon_e.od0, mon_e.chk0, mon_e.od1, mon_e.chk1);
            end
        end
    end

    initial begin
        // Reset state and single-word write.
        step("reset0", 1, IDLE, 8'h00, 8'h00, IDLE);
        step("reset1", 1, ONE, 8'hFF, 8'hFF, ONE);
        step("wr_a5", 0, ONE, 8'hA5, 8'h00, IDLE);
        step("hold_a5", 0, IDLE, 8'h00, 8'h00, IDLE);
        step("bad_codes", 0, 3'b011, 8'h99, 8'h98, 3'b000);
        step("bad_codes2", 0, 3'b111, 8'h97, 8'h96, 3'b110);

        // Two-word write then two-word read.
        step("reset2", 1, IDLE, 8'h00, 8'h00, IDLE);
        step("wr2_11_22", 0, TWO, 8'h11, 8'h22, IDLE);
        step("rd2", 0, IDLE, 8'h00, 8'h00, TWO);
        step("rd1_leftover", 0, IDLE, 8'h00, 8'h00, ONE);

        // Fill to 30, then probe the full boundaries.
        step("reset3", 1, IDLE, 8'h00, 8'h00, IDLE);
        for (int i = 0; i < 30; i++) step("fill", 0, ONE, 8'(i + 1), 8'h00, IDLE);
        step("wr2_at30", 0, TWO, 8'hEE, 8'hEF, IDLE);
        step("wr1_at30", 0, ONE, 8'h77, 8'h00, IDLE);
        step("wr1_full", 0, ONE, 8'h78, 8'h00, IDLE);
        step("wr2_full", 0, TWO, 8'h79, 8'h7A, IDLE);
        step("rw_full", 0, ONE, 8'h7B, 8'h00, ONE);
        for (int i = 0; i < 8; i++) step("drain2", 0, IDLE, 8'h00, 8'h00, TWO);
        for (int i = 0; i < 32; i++) step("drain1", 0, IDLE, 8'h00, 8'h00, ONE);

        // Two-word read blocked with one word stored.
        step("reset4", 1, IDLE, 8'h00, 8'h00, IDLE);
        step("wr_5a", 0, ONE, 8'h5A, 8'h00, IDLE);
        step("rd2_blocked", 0, IDLE, 8'h00, 8'h00, TWO);
        step("rd1_last", 0, IDLE, 8'h00, 8'h00, ONE);

        // Move both pointers to slot 31, then straddle the wrap.
        step("reset5", 1, IDLE, 8'h00, 8'h00, IDLE);
        for (int i = 0; i < 31; i++) step("wrap_fill", 0, ONE, 8'(8'h80 + i), 8'h00, IDLE);
        for (int i = 0; i < 31; i++) step("wrap_drain", 0, IDLE, 8'h00, 8'h00, ONE);
        step("wr2_wrap", 0, TWO, 8'h33, 8'h44, IDLE);
        step("rw_same", 0, ONE, 8'h55, 8'h00, ONE);
        step("wr_66", 0, ONE, 8'h66, 8'h00, IDLE);
        step("rd2_wrap", 0, IDLE, 8'h00, 8'h00, TWO);
        for (int i = 0; i < 3; i++) step("rd1_wrap", 0, IDLE, 8'h00, 8'h00, ONE);

        // Reset in the middle of traffic discards everything.
        for (int i = 0; i < 17; i++) step("pre_rst", 0, ONE, 8'(8'h40 + i), 8'h00, IDLE);
        step("rst_mid", 1, ONE, 8'hC3, 8'hC4, ONE);
        step("after_rst", 0, IDLE, 8'h00, 8'h00, IDLE);
        step("wr_after_rst", 0, ONE, 8'h3C, 8'h00, IDLE);
        step("rd2_after_rst", 0, IDLE, 8'h00, 8'h00, TWO);

        rst = 1'b0; wrreq = IDLE; rdreq = IDLE;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending entries, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/preview_fifo.md
PREVIEW_FIFO -- requirements
Module: preview_fifo

Interface
- REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
- REQ-002 SHALL have parameter DEPTH, default 32: storage slots, a power of two; usable capacity DEPTH-1 words.
- REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-005 SHALL have port wrreq, input, 3 bits: one-hot write command; 3'b001 = idle, 3'b010 = write one word, 3'b100 = write two words.
- REQ-006 SHALL have port id0, input, WIDTH bits: first (older) write word.
- REQ-007 SHALL have port id1, input, WIDTH bits: second write word, used only for two-word writes.
- REQ-008 SHALL have port rdreq, input, 3 bits: one-hot read command, encoded the same way as wrreq.
- REQ-009 SHALL have port od0, output, WIDTH bits: preview of the head (oldest) word.
- REQ-010 SHALL have port od1, output, WIDTH bits: preview of the word behind the head.
- REQ-011 SHALL have port empty, output, 2 bits: empty[0] = less than 1 word stored; empty[1] = less than 2 words stored.
- REQ-012 SHALL have port full, output, 2 bits: full[0] = no room for 1 word; full[1] = no room for 2 words.
- REQ-013 SHALL have port usedw, output, $clog2(DEPTH) bits: current word count, range 0..DEPTH-1.

Function
- REQ-014 od0/od1 SHALL be first-word-fall-through: combinational reads of mem[rd_ptr] and mem[rd_ptr+1], with no read latency.
- REQ-015 A one-word write SHALL store id0 at wr_ptr and advance wr_ptr by 1, only when full[0]=0.
- REQ-016 A two-word write SHALL store id0 at wr_ptr and id1 at wr_ptr+1, then advance wr_ptr by 2, only when full[1]=0.
- REQ-017 A one-word read SHALL advance rd_ptr by 1, only when empty[0]=0.
- REQ-018 A two-word read SHALL advance rd_ptr by 2, only when empty[1]=0.
- REQ-019 A blocked request (full or empty for its size) SHALL be ignored entirely, with no partial transfer.
- REQ-020 Any wrreq or rdreq code other than 3'b010 or 3'b100 SHALL act as idle.
- REQ-021 Reads and writes SHALL be allowed in the same cycle.
- REQ-022 Full and empty checks SHALL use the flags before the cycle's update, so a read in a cycle does not free room for a write in that same cycle.
- REQ-023 After each edge, usedw SHALL equal usedw + accepted write words - accepted read words.
- REQ-024 Flags SHALL be registered and consistent with usedw: empty[0] = (usedw==0), empty[1] = (usedw<2), full[0] = (usedw==DEPTH-1), full[1] = (usedw>=DEPTH-2).
- REQ-025 Pointers SHALL wrap modulo DEPTH, and two-word accesses SHALL split across the wrap (slot DEPTH-1, then slot 0).
- REQ-026 When fewer than 2 words are stored, od1 SHALL show stale memory content; when the FIFO is empty, od0 SHALL also show stale memory content; neither is guaranteed data.

Reset
- REQ-027 While rst=1 at a clock edge: pointers = 0, usedw = 0, empty = 2'b11, full = 2'b00, all memory words cleared, so od0 = od1 = 0.
- REQ-028 Reset SHALL take priority over any concurrent wrreq or rdreq.
- REQ-029 A reset during operation SHALL discard all stored data, with no residual words visible afterwards.

Configuration
- REQ-030 Macro PREVIEW_FIFO_TWO_WORD_EN defined: two-word writes and reads operate as specified above.
- REQ-031 Macro PREVIEW_FIFO_TWO_WORD_EN undefined: code 3'b100 on wrreq or rdreq SHALL be treated as idle; od1, empty[1] and full[1] remain implemented unchanged.

Structure
- REQ-032 Package preview_fifo_pkg SHALL hold the command encodings: CMD_IDLE=3'b001, CMD_ONE=3'b010, CMD_TWO=3'b100.
- REQ-033 The block SHALL be a single module with an internal register-array memory and no sub-modules.

Verification
- REQ-034 Scenario: after reset, write one word 8'hA5 -> next cycle od0=A5, usedw=1, empty=2'b10, full=2'b00.
- REQ-035 Scenario: two-word write with id0=11, id1=22 into an empty FIFO -> od0=11, od1=22, usedw=2, empty=2'b00; a following two-word read returns usedw=0, empty=2'b11.
- REQ-036 Scenario: fill to 30 words; a two-word write is rejected (full[1]=1) while a one-word write is accepted -> usedw=31, full=2'b11; further writes leave usedw=31.
- REQ-037 Scenario: with usedw=1, a two-word read is ignored (usedw stays 1, od0 unchanged); a one-word read then gives usedw=0.
- REQ-038 Scenario: with wr_ptr=rd_ptr=31 and the FIFO empty, a two-word write of 33,44 -> od0=33, od1=44 across the wrap; a simultaneous one-word read and one-word write at usedw=2 keeps usedw=2.
- REQ-039 Scenario: assert rst with usedw=17 while a write is requested -> next cycle usedw=0, empty=2'b11, od0=0.
